// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scheduler.
// Digit/nibble geometry, FSM encoding and small scan helpers.
package display_scheduler_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned WORD_W   = DIGITS * NIBBLE_W;
  localparam int unsigned IDX_W    = 2;

  localparam logic [DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    anode_sel = ~(DIGITS'(1) << idx);
  endfunction

  // Nibble of a display word for a given digit position (digit0 = LSBs).
  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [WORD_W-1:0] w,
                                                    input logic [IDX_W-1:0]  idx);
    nibble_of = NIBBLE_W'(w >> (NIBBLE_W * 32'(idx)));
  endfunction

endpackage

// File: rtl/display_scheduler_scan_tick_gen.sv
// Free-running prescaler producing a one-clk scan tick each time it wraps to zero.
module display_scheduler_scan_tick_gen #(
  parameter int unsigned DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic             tick_q;

  // tick_q is high in the cycle where the counter reads zero after a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + DIV_W'(1);
      tick_q <= &cnt_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/display_scheduler.sv
// Shares a 4-digit multiplexed 7-seg display between NREQ requesters.
// Round-robin grant per frame with minimum hold, per-frame word refresh and digit scan.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DIV_W       = 17,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [WORD_W*NREQ-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [NIBBLE_W-1:0]    digit,
  output logic [DIGITS-1:0]      an,
  output logic                   busy
);

  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned HCMP_W = HOLD_W + 1;
  localparam logic [HCMP_W-1:0] HOLD_LIM = HCMP_W'(HOLD_FRAMES);

  state_e              state_q, state_d;
  logic                tick;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    cand, load_sel;
  logic                cand_vld;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HCMP_W-1:0]   hold_inc;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_step;
  logic [WORD_W-1:0]   word_q, word_d, load_word;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [NIBBLE_W-1:0] digit_q, digit_d;
  logic                busy_q, busy_d;
  logic                boundary, own_req, other_req;
  logic                do_load, do_blank, do_step;
  logic [WORD_W-1:0]   data_arr [NREQ];

  display_scheduler_scan_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = WORD_W'(data >> (WORD_W * i));
    end
  end

  // First requester found searching upward from rr+1, wrapping mod NREQ.
  always_comb begin
    int unsigned pos;
    pos      = 0;
    cand_vld = 1'b0;
    cand     = rr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = (32'(rr_q) + k) % NREQ;
      if (!cand_vld && req[PTR_W'(pos)]) begin
        cand_vld = 1'b1;
        cand     = PTR_W'(pos);
      end
    end
  end

  assign boundary  = tick && (idx_q == IDX_W'(DIGITS - 1));
  assign own_req   = |(req & grant_q);
  assign other_req = |(req & ~grant_q);
  assign hold_inc  = HCMP_W'(hold_q) + HCMP_W'(1);
  assign idx_step  = idx_q + IDX_W'(1);
  assign load_word = data_arr[load_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tick && cand_vld) state_d = ST_SHOW;
      ST_SHOW: if (boundary && !own_req && !other_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decide per tick whether to load a new/kept owner, blank, or advance the scan.
  always_comb begin
    rr_d     = rr_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    word_d   = word_q;
    grant_d  = grant_q;
    an_d     = an_q;
    digit_d  = digit_q;
    busy_d   = busy_q;
    do_load  = 1'b0;
    do_blank = 1'b0;
    do_step  = 1'b0;
    load_sel = rr_q;

    case (state_q)
      ST_IDLE: begin
        if (tick && cand_vld) begin
          do_load  = 1'b1;
          load_sel = cand;
          hold_d   = '0;
        end
      end
      ST_SHOW: begin
        if (boundary) begin
          if (!own_req && !other_req) begin
            do_blank = 1'b1;
          end else if (!own_req || (hold_inc >= HOLD_LIM && other_req)) begin
            do_load  = 1'b1;
            load_sel = cand;
            hold_d   = '0;
          end else begin
            do_load  = 1'b1;
            load_sel = rr_q;
            if (hold_inc < HOLD_LIM) hold_d = HOLD_W'(hold_inc);
          end
        end else if (tick) begin
          do_step = 1'b1;
        end
      end
      default: begin
        do_blank = 1'b1;
      end
    endcase

    // A load always restarts the frame at digit 0 with the freshly latched word.
    if (do_load) begin
      rr_d    = load_sel;
      word_d  = load_word;
      idx_d   = '0;
      grant_d = NREQ'(1) << load_sel;
      an_d    = anode_sel(IDX_W'(0));
      digit_d = nibble_of(load_word, IDX_W'(0));
      busy_d  = 1'b1;
    end else if (do_blank) begin
      idx_d   = '0;
      grant_d = '0;
      an_d    = ANODE_OFF;
      digit_d = '0;
      busy_d  = 1'b0;
    end else if (do_step) begin
      idx_d   = idx_step;
      an_d    = anode_sel(idx_step);
      digit_d = nibble_of(word_q, idx_step);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      grant_q <= '0;
      an_q    <= ANODE_OFF;
      digit_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      grant_q <= grant_d;
      an_q    <= an_d;
      digit_q <= digit_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign digit = digit_q;
  assign an    = an_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed vector table, reset-in-frame sequence,
// and random traffic scored against a frame-level reference model.
module tb_display_scheduler;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DIV_W  = 2;
  localparam int          HOLD   = 2;
  localparam int          PERIOD = 4;
  localparam int unsigned PTR_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   data;
  logic [NREQ-1:0]      grant;
  logic [3:0]           digit;
  logic [3:0]           an;
  logic                 busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  display_scheduler #(
    .NREQ        (NREQ),
    .DIV_W       (DIV_W),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .grant (grant),
    .digit (digit),
    .an    (an),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: owner/frame behaviour stepped once per clock.
  typedef struct {
    int         owner;
    int         rr;
    int         hold;
    int         idx;
    int         k;
    logic [15:0] word;
    logic [3:0]  an;
    logic [3:0]  digit;
  } mstate_t;

  mstate_t m = '{owner: -1, rr: 0, hold: 0, idx: 0, k: 0, word: 16'h0, an: 4'hF, digit: 4'h0};

  function automatic int pick(input int rr, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[PTR_W'((rr + k) % NREQ)]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t cur, input logic r,
                                         input logic [NREQ-1:0] rq,
                                         input logic [16*NREQ-1:0] d);
    mstate_t s;
    int      w;
    logic    own, others;
    s = cur;
    if (r) begin
      s = '{owner: -1, rr: 0, hold: 0, idx: 0, k: 0, word: 16'h0, an: 4'hF, digit: 4'h0};
      return s;
    end
    s.k++;
    // Scan ticks act on clocks PERIOD+1, 2*PERIOD+1, ... after reset release.
    if (s.k <= PERIOD || (s.k % PERIOD) != 1) return s;
    w = pick(s.rr, rq);
    if (s.owner < 0) begin
      if (w < 0) return s;
      s.owner = w; s.rr = w; s.hold = 0;
      s.word  = 16'(d >> (16 * w));
      s.idx   = 0;
    end else if (s.idx == 3) begin
      own    = rq[PTR_W'(s.owner)];
      others = (rq & ~(NREQ'(1) << s.owner)) != '0;
      if (!own && !others) begin
        s.owner = -1; s.idx = 0; s.an = 4'hF; s.digit = 4'h0;
        return s;
      end
      if (!own || (s.hold + 1 >= HOLD && others)) begin
        s.owner = w; s.rr = w; s.hold = 0;
      end else if (s.hold + 1 < HOLD) begin
        s.hold++;
      end
      s.word = 16'(d >> (16 * s.owner));
      s.idx  = 0;
    end else begin
      s.idx++;
    end
    s.an    = ~(4'b0001 << s.idx);
    s.digit = 4'(s.word >> (4 * s.idx));
    return s;
  endfunction

  function automatic logic [12:0] expect_of(input mstate_t s);
    logic [3:0] g;
    g = (s.owner < 0) ? 4'b0000 : (NREQ'(1) << s.owner);
    return {g, s.an, s.digit, s.owner >= 0};
  endfunction

  always @(posedge clk) m <= model_next(m, rst, req, data);

  always @(negedge clk) begin
    if (chk_en) check("model{grant,an,digit,busy}", 32'({grant, an, digit, busy}), 32'(expect_of(m)));
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    int          clks;
    logic [3:0]  g;
    logic [3:0]  an;
    logic [3:0]  dg;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = {16'hC0DE, 16'hF00D, 16'h0000, 16'h0000};

    // req, d0, d1, clks-to-wait, expected grant, an, digit, busy
    tbl.push_back('{4'b0000, 16'h0000, 16'h0000, 40, 4'b0000, 4'b1111, 4'h0, 1'b0});
    tbl.push_back('{4'b0010, 16'h0000, 16'h1234,  1, 4'b0010, 4'b1110, 4'h4, 1'b1});
    tbl.push_back('{4'b0010, 16'h0000, 16'h1234,  2, 4'b0010, 4'b1110, 4'h4, 1'b1});
    tbl.push_back('{4'b0010, 16'h0000, 16'h1234,  2, 4'b0010, 4'b1101, 4'h3, 1'b1});
    tbl.push_back('{4'b0010, 16'h0000, 16'h1234,  4, 4'b0010, 4'b1011, 4'h2, 1'b1});
    tbl.push_back('{4'b0010, 16'h0000, 16'h1234,  4, 4'b0010, 4'b0111, 4'h1, 1'b1});
    tbl.push_back('{4'b0010, 16'h0000, 16'h1234,  4, 4'b0010, 4'b1110, 4'h4, 1'b1});
    tbl.push_back('{4'b0000, 16'h0000, 16'h1234, 12, 4'b0010, 4'b0111, 4'h1, 1'b1});
    tbl.push_back('{4'b0000, 16'h0000, 16'h1234,  4, 4'b0000, 4'b1111, 4'h0, 1'b0});
    tbl.push_back('{4'b0011, 16'h00AA, 16'h1234,  4, 4'b0001, 4'b1110, 4'hA, 1'b1});
    tbl.push_back('{4'b0011, 16'h00AA, 16'h1234, 28, 4'b0001, 4'b0111, 4'h0, 1'b1});
    tbl.push_back('{4'b0011, 16'h00AA, 16'h1234,  4, 4'b0010, 4'b1110, 4'h4, 1'b1});
    tbl.push_back('{4'b0011, 16'h00AA, 16'h1234, 28, 4'b0010, 4'b0111, 4'h1, 1'b1});
    tbl.push_back('{4'b0011, 16'h00AA, 16'h1234,  4, 4'b0001, 4'b1110, 4'hA, 1'b1});
    tbl.push_back('{4'b0001, 16'h00BB, 16'h1234,  4, 4'b0001, 4'b1101, 4'hA, 1'b1});
    tbl.push_back('{4'b0001, 16'h00BB, 16'h1234,  4, 4'b0001, 4'b1011, 4'h0, 1'b1});
    tbl.push_back('{4'b0001, 16'h00BB, 16'h1234,  4, 4'b0001, 4'b0111, 4'h0, 1'b1});
    tbl.push_back('{4'b0001, 16'h00BB, 16'h1234,  4, 4'b0001, 4'b1110, 4'hB, 1'b1});
    tbl.push_back('{4'b0001, 16'h00BB, 16'h1234,  4, 4'b0001, 4'b1101, 4'hB, 1'b1});
    tbl.push_back('{4'b0001, 16'h00BB, 16'h1234,  4, 4'b0001, 4'b1011, 4'h0, 1'b1});

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_an",    32'(an),    32'hF);
    check("reset_digit", 32'(digit), 32'h0);
    check("reset_busy",  32'(busy),  32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req         = tbl[i].req;
      data[15:0]  = tbl[i].d0;
      data[31:16] = tbl[i].d1;
      repeat (tbl[i].clks) @(negedge clk);
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("vec%0d_an", i),    32'(an),    32'(tbl[i].an));
      check($sformatf("vec%0d_digit", i), 32'(digit), 32'(tbl[i].dg));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
    end

    // Reset while showing digit 2, then re-grant from a clean frame.
    rst = 1'b1;
    @(negedge clk);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_an",    32'(an),    32'hF);
    check("midrst_digit", 32'(digit), 32'h0);
    check("midrst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("regrant_wait_an", 32'(an), 32'hF);
    @(negedge clk);
    check("regrant_grant", 32'(grant), 32'b0001);
    check("regrant_an",    32'(an),    32'b1110);
    check("regrant_digit", 32'(digit), 32'hB);
    repeat (4) @(negedge clk);
    check("regrant_idx1_an",    32'(an),    32'b1101);
    check("regrant_idx1_digit", 32'(digit), 32'hB);

    // Random traffic, occasional resets; the per-cycle model check scores it.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) req = 4'($urandom);
      if ($urandom_range(7) == 0) begin
        data[31:0]  = $urandom;
        data[63:32] = $urandom;
      end
      rst = ($urandom_range(499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
